// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 slave exposing a 32x8 register file.
// Optional macro SPI_RESP_IRQ_EN turns STATUS_ADDR into a set/W1C status register driving irq.
module spi_reg_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] STATUS_ADDR = 5'd25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    input  logic       loc_we,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       irq
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_q;
    logic                   ss_q;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx;
    logic [7:0]             tx;
    logic [4:0]             addr;
    logic                   dir;
    logic                   byte_done;
    logic [7:0]             regs [32];

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic       active;
    logic [7:0] rx_next;
    logic       spi_we;

    // Synchronizers run through reset so a held-low ss_n never fakes a falling edge afterwards.
    always_ff @(posedge clk) begin
        sclk_sync[0] <= spi_sclk;
        ss_sync[0]   <= spi_ss_n;
        mosi_sync[0] <= spi_mosi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync[i] <= sclk_sync[i-1];
            ss_sync[i]   <= ss_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
        end
        sclk_q <= sclk_s;
        ss_q   <= ss_s;
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign ss_rise   = ss_s & ~ss_q;
    assign ss_fall   = ~ss_s & ss_q;
    assign active    = (state != IDLE) && !ss_s;
    assign rx_next   = {rx[6:0], mosi_s};
    assign spi_we    = active && sclk_rise && (bit_cnt == 3'd7) && (state == DATA) && dir;

    assign loc_rdata = regs[loc_addr];
    assign spi_miso  = tx[7] & spi_miso_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx          <= 8'h00;
            tx          <= 8'h00;
            addr        <= 5'd0;
            dir         <= 1'b0;
            byte_done   <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 5'd0;
            wr_data     <= 8'h00;
        end else begin
            wr_strobe <= spi_we;
            if (spi_we) begin
                wr_addr <= addr;
                wr_data <= rx_next;
            end
            if (ss_rise) begin
                state       <= IDLE;
                bit_cnt     <= 3'd0;
                byte_done   <= 1'b0;
                tx          <= 8'h00;
                spi_miso_oe <= 1'b0;
            end else if (state == IDLE) begin
                if (ss_fall) begin
                    state       <= CMD;
                    bit_cnt     <= 3'd0;
                    byte_done   <= 1'b0;
                    tx          <= regs[STATUS_ADDR];
                    spi_miso_oe <= 1'b1;
                end
            end else if (active) begin
                if (sclk_rise) begin
                    rx      <= rx_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done <= 1'b1;
                        if (state == CMD) begin
                            addr  <= rx_next[7:3];
                            dir   <= rx_next[1];
                            state <= DATA;
                        end
                    end
                end else if (sclk_fall) begin
                    // The first falling edge after a completed byte reloads from the addressed register.
                    if (byte_done) begin
                        tx        <= regs[addr];
                        byte_done <= 1'b0;
                    end else begin
                        tx <= {tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // The SPI write is assigned last so it overrides a local write to the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: 8'h00};
        end else begin
            if (loc_we) begin
`ifdef SPI_RESP_IRQ_EN
                if (loc_addr == STATUS_ADDR)
                    regs[loc_addr] <= regs[loc_addr] | loc_wdata;
                else
                    regs[loc_addr] <= loc_wdata;
`else
                regs[loc_addr] <= loc_wdata;
`endif
            end
            if (spi_we) begin
`ifdef SPI_RESP_IRQ_EN
                if (addr == STATUS_ADDR)
                    regs[addr] <= regs[addr] & ~rx_next;
                else
                    regs[addr] <= rx_next;
`else
                regs[addr] <= rx_next;
`endif
            end
        end
    end

`ifdef SPI_RESP_IRQ_EN
    localparam logic [4:0] IRQ_MASK_ADDR = STATUS_ADDR + 5'd1;

    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= |(regs[STATUS_ADDR] & regs[IRQ_MASK_ADDR]);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - table-driven and randomized bench for spi_reg_responder.
module tb_spi_reg_responder;

    localparam int         SYNC   = 2;
    localparam logic [4:0] STATUS = 5'd25;
    localparam int         HALF   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sclk, spi_ss_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [4:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       loc_we;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       irq;

    spi_reg_responder #(.SYNC_STAGES(SYNC), .STATUS_ADDR(STATUS)) dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(loc_we), .loc_rdata(loc_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic       pre_en;
        logic [7:0] pre;
        logic [4:0] chk;
        logic [7:0] exp_miso1;
        logic [7:0] exp_reg;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         strobe_cnt = 0;
    int         exp_strobes = 0;
    logic [7:0] model [32];
    logic [7:0] got [4];
    vec_t       tbl [6];

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void m_loc(input logic [4:0] a, input logic [7:0] d);
`ifdef SPI_RESP_IRQ_EN
        if (a == STATUS) model[a] = model[a] | d;
        else model[a] = d;
`else
        model[a] = d;
`endif
    endfunction

    function automatic void m_spi(input logic [4:0] a, input logic [7:0] d);
`ifdef SPI_RESP_IRQ_EN
        if (a == STATUS) model[a] = model[a] & ~d;
        else model[a] = d;
`else
        model[a] = d;
`endif
    endfunction

    function automatic logic m_irq();
`ifdef SPI_RESP_IRQ_EN
        return |(model[STATUS] & model[STATUS+5'd1]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        step(1);
        loc_we = 1'b0;
        m_loc(a, d);
    endtask

    task automatic read_reg(input logic [4:0] a, input logic [7:0] exp, input string name);
        loc_addr = a;
        #1;
        check(name, loc_rdata, exp);
    endtask

    // Master side of one byte, MSB first; optional local write aligned to the SPI write cycle.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit coll,
                            input logic [4:0] ca, input logic [7:0] cd, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            step(HALF);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            if (coll && i == 0) begin
                step(SYNC);
                loc_addr = ca; loc_wdata = cd; loc_we = 1'b1;
                step(1);
                loc_we = 1'b0;
                check("collision_strobe", wr_strobe, 1'b1);
                m_loc(ca, cd);
                step(HALF - SYNC - 1);
            end else begin
                step(HALF);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_txn(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input int n, input bit coll,
                           input logic [4:0] ca, input logic [7:0] cd);
        logic [7:0] exp, r, d;
        logic [4:0] a;
        a = cmd[7:3];
        spi_ss_n = 1'b0;
        step(HALF);
        check("oe_after_ss_fall", spi_miso_oe, 1'b1);
        exp = model[STATUS];
        spi_byte(cmd, 8, 1'b0, 5'd0, 8'h00, r);
        got[0] = r;
        check("miso_status_byte", r, exp);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            exp = model[a];
            spi_byte(d, 8, coll && (k == n - 1), ca, cd, r);
            got[k+1] = r;
            check($sformatf("miso_data_byte%0d_addr%0d", k, a), r, exp);
            if (cmd[1]) begin
                m_spi(a, d);
                exp_strobes++;
            end
        end
        step(HALF);
        spi_ss_n = 1'b1;
        step(HALF + 2);
        check("oe_after_ss_rise", spi_miso_oe, 1'b0);
        check("miso_idle", spi_miso, 1'b0);
        check("strobe_count", strobe_cnt, exp_strobes);
    endtask

    initial begin
        logic [7:0] r;
        int         s0;
        reset = 1'b1; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
        loc_addr = 5'd0; loc_wdata = 8'h00; loc_we = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        tbl[0] = '{8'hA2, 8'h5C, 1'b0, 8'h00, 5'd20, 8'h00, 8'h5C};
        tbl[1] = '{8'h38, 8'h00, 1'b1, 8'h3B, 5'd7,  8'h3B, 8'h3B};
        tbl[2] = '{8'h4D, 8'h00, 1'b1, 8'hE7, 5'd9,  8'hE7, 8'hE7};
        tbl[3] = '{8'hFB, 8'h80, 1'b1, 8'h12, 5'd31, 8'h12, 8'h80};
        tbl[4] = '{8'h06, 8'hFF, 1'b0, 8'h00, 5'd0,  8'h00, 8'hFF};
        tbl[5] = '{8'h87, 8'h00, 1'b1, 8'hA5, 5'd16, 8'hA5, 8'h00};
        step(4);
        reset = 1'b0;
        step(1);

        check("reset_oe", spi_miso_oe, 1'b0);
        check("reset_miso", spi_miso, 1'b0);
        check("reset_strobe", wr_strobe, 1'b0);
        check("reset_irq", irq, 1'b0);
        check("reset_wr_addr", wr_addr, 5'd0);
        check("reset_wr_data", wr_data, 8'h00);
        read_reg(5'd0, 8'h00, "reset_reg0");
        read_reg(5'd25, 8'h00, "reset_reg25");

        loc_write(STATUS, 8'hC3);
        read_reg(STATUS, 8'hC3, "status_preload");

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].pre_en) loc_write(tbl[i].chk, tbl[i].pre);
            spi_txn(tbl[i].cmd, tbl[i].data, 8'h00, 8'h00, 1, 1'b0, 5'd0, 8'h00);
            check($sformatf("tbl%0d_miso0", i), got[0], 8'hC3);
            check($sformatf("tbl%0d_miso1", i), got[1], tbl[i].exp_miso1);
            read_reg(tbl[i].chk, tbl[i].exp_reg, $sformatf("tbl%0d_reg", i));
            if (tbl[i].cmd[1]) begin
                check($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].chk);
                check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].exp_reg);
            end
        end

        s0 = strobe_cnt;
        spi_txn(8'h0A, 8'h11, 8'h22, 8'h33, 3, 1'b0, 5'd0, 8'h00);
        check("burst_miso1", got[1], 8'h00);
        check("burst_miso2", got[2], 8'h11);
        check("burst_miso3", got[3], 8'h22);
        read_reg(5'd1, 8'h33, "burst_reg1");
        check("burst_strobes", strobe_cnt - s0, 3);

        loc_write(5'd3, 8'h77);
        s0 = strobe_cnt;
        spi_ss_n = 1'b0;
        step(HALF);
        spi_byte(8'h1A, 8, 1'b0, 5'd0, 8'h00, r);
        spi_byte(8'hFF, 5, 1'b0, 5'd0, 8'h00, r);
        step(HALF);
        spi_ss_n = 1'b1;
        step(HALF + 2);
        check("abort_oe", spi_miso_oe, 1'b0);
        check("abort_miso", spi_miso, 1'b0);
        read_reg(5'd3, 8'h77, "abort_reg3");
        check("abort_strobes", strobe_cnt, s0);

        for (int i = 0; i < 8; i++) begin
            spi_sclk = ~spi_sclk;
            spi_mosi = 1'($urandom_range(0, 1));
            step(HALF);
        end
        check("sclk_ss_high_oe", spi_miso_oe, 1'b0);
        check("sclk_ss_high_strobes", strobe_cnt, s0);

        spi_txn(8'h4A, 8'hAA, 8'h00, 8'h00, 1, 1'b1, 5'd9, 8'h55);
        read_reg(5'd9, 8'hAA, "collision_same_addr");
        spi_txn(8'h4A, 8'h3C, 8'h00, 8'h00, 1, 1'b1, 5'd10, 8'h55);
        read_reg(5'd9, 8'h3C, "collision_diff_spi");
        read_reg(5'd10, 8'h55, "collision_diff_loc");

        for (int t = 0; t < 25; t++) begin
            logic [7:0] c;
            if ($urandom_range(0, 1) == 1) loc_write(5'($urandom), 8'($urandom));
            c = 8'($urandom);
            spi_txn(c, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3),
                    1'b0, 5'd0, 8'h00);
            check($sformatf("rand%0d_irq", t), irq, m_irq());
        end
        for (int a = 0; a < 32; a++) read_reg(5'(a), model[a], $sformatf("rand_reg%0d", a));

        loc_write(5'd4, 8'h99);
        s0 = strobe_cnt;
        spi_ss_n = 1'b0;
        step(HALF);
        spi_byte(8'h22, 8, 1'b0, 5'd0, 8'h00, r);
        spi_byte(8'hF0, 3, 1'b0, 5'd0, 8'h00, r);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        read_reg(5'd4, 8'h00, "midreset_reg4");
        check("midreset_oe", spi_miso_oe, 1'b0);
        check("midreset_wr_data", wr_data, 8'h00);
        spi_byte(8'hAB, 8, 1'b0, 5'd0, 8'h00, r);
        step(HALF);
        check("midreset_no_resume_oe", spi_miso_oe, 1'b0);
        check("midreset_no_resume_strobes", strobe_cnt, s0);
        read_reg(5'd4, 8'h00, "midreset_no_resume_reg4");
        spi_ss_n = 1'b1;
        step(HALF + 2);
        spi_txn(8'h22, 8'h5A, 8'h00, 8'h00, 1, 1'b0, 5'd0, 8'h00);
        read_reg(5'd4, 8'h5A, "fresh_txn_reg4");

        loc_write(5'd26, 8'h01);
        check("irq_mask_only", irq, 1'b0);
        loc_addr = STATUS; loc_wdata = 8'h01; loc_we = 1'b1;
        step(1);
        loc_we = 1'b0;
        m_loc(STATUS, 8'h01);
        step(1);
        check("irq_after_set", irq, m_irq());
`ifdef SPI_RESP_IRQ_EN
        check("irq_set_const", irq, 1'b1);
`endif
        spi_txn(8'hCA, 8'h01, 8'h00, 8'h00, 1, 1'b0, 5'd0, 8'h00);
        read_reg(STATUS, model[STATUS], "status_after_spi_write");
        check("irq_after_clear", irq, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
